// File: rtl/instr_mem_responder.sv
// instr_mem_responder: responder end of the instruction-fetch interface.
// Grants fetch requests, returns words from an internal word-addressed memory
// after a fixed latency (strictly in order), flags bad addresses with an
// error/NOP response, and accepts memory fills through a side load port.
module instr_mem_responder #(
  parameter int          DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = 3;

  logic [31:0]      mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [32:0]      fetch_off;
  logic [32:0]      load_off;
  logic             fetch_err;
  logic [31:0]      fetch_word;
  logic             xfer;
  logic             retire;
  logic             tail_vld;
  logic [32:0]      tail_word;

  // Offsets are taken 33 bits wide so an address below the base wraps to a
  // value with bit 32 set, which always fails the span check.
  function automatic logic in_window(input logic [32:0] off);
    return (off < SPAN) && (off[1:0] == 2'b00);
  endfunction

  assign fetch_off = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
  assign load_off  = {1'b0, load_addr_i} - {1'b0, BASE_ADDR};

  // A response leaving the pipe frees a slot in the same cycle, so a full
  // responder can still grant while it retires.
  assign retire      = instr_rvalid_o;
  assign instr_gnt_o = instr_req_i & ~load_we_i &
                       ((count < CNT_W'(MAX_OUTSTANDING)) | retire);
  assign xfer        = instr_req_i & instr_gnt_o;

  // Bad addresses never touch the memory; they answer with a NOP word.
  assign fetch_err  = ~in_window(fetch_off);
  assign fetch_word = fetch_err ? NOP : mem[fetch_off[IDX_W+1:2]];

  // Load port write; misaligned or out-of-window writes are dropped.
  always_ff @(posedge clk_i) begin
    if (load_we_i && in_window(load_off)) begin
      mem[load_off[IDX_W+1:2]] <= load_wdata_i;
    end
  end

  // Outstanding-request counter: up on transfer, down on response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else begin
      case ({xfer, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] vld_p;
      logic [32:0]        stage_p [LATENCY-1];

      // Valid bits of the intermediate latency stages; cleared on reset so
      // in-flight responses are dropped.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= xfer;
          for (int k = 1; k < LATENCY - 1; k++) begin
            vld_p[k] <= vld_p[k-1];
          end
        end
      end

      // Error flag and word ride alongside the valid bits.
      always_ff @(posedge clk_i) begin
        stage_p[0] <= {fetch_err, fetch_word};
        for (int k = 1; k < LATENCY - 1; k++) begin
          stage_p[k] <= stage_p[k-1];
        end
      end

      assign tail_vld  = vld_p[LATENCY-2];
      assign tail_word = stage_p[LATENCY-2];
    end else begin : g_direct
      assign tail_vld  = xfer;
      assign tail_word = {fetch_err, fetch_word};
    end
  endgenerate

  // Output stage: data and error hold their last value while no response is due.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= '0;
      instr_err_o    <= 1'b0;
    end else begin
      instr_rvalid_o <= tail_vld;
      if (tail_vld) begin
        instr_err_o   <= tail_word[32];
        instr_rdata_o <= tail_word[31:0];
      end
    end
  end

endmodule
